// File: rtl/cordic_floatingpoint_fifo_writer.sv
// Producer side of the CORDIC input FIFO: splits each operand into SEG_W-bit words, MS segment first.
// Optional macro CORDIC_FP_TRAILING_ZERO_SKIP_EN stops each job after its last nonzero segment.
module cordic_floatingpoint_fifo_writer #(
    parameter int DATA_W = 32,
    parameter int SEG_W  = 8
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DATA_W-1:0] iData,
    input  logic [3:0]        iRecovery_info,
    input  logic              iFifo_full,
    output logic              oFifo_wrreq,
    output logic [SEG_W+5:0]  oFifo_data,
    output logic              oBusy
);
    // state | meaning
    // IDLE  | waiting for an operand, oReady high
    // EMIT  | writing the registered operand's segments into the FIFO
    localparam int NUM_SEG = DATA_W / SEG_W;
    localparam int CNT_W   = $clog2(NUM_SEG + 1);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic [3:0]          r_rec;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_seg;
    logic                r_zero;

    logic [CNT_W-1:0]    w_count;
    logic                w_final;
    logic [1:0]          w_last_rot;

    always_comb begin
        w_count = CNT_W'(1);
        if (iData != '0) begin
`ifdef CORDIC_FP_TRAILING_ZERO_SKIP_EN
            for (int k = 0; k < NUM_SEG; k++) begin
                if (iData[DATA_W-1-k*SEG_W -: SEG_W] != '0)
                    w_count = CNT_W'(k + 1);
            end
`else
            w_count = CNT_W'(NUM_SEG);
`endif
        end
    end

    assign w_final    = (r_seg == (r_count - CNT_W'(1)));
    assign w_last_rot = r_zero ? 2'b10 : (w_final ? 2'b01 : 2'b00);

    assign oReady      = (r_state == IDLE);
    assign oBusy       = (r_state == EMIT);
    assign oFifo_wrreq = (r_state == EMIT) && !iFifo_full;
    // The working copy is shifted left on each write, so the current segment is always on top.
    assign oFifo_data  = {r_rec, w_last_rot, r_data[DATA_W-1 -: SEG_W]};

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rec   <= '0;
            r_count <= '0;
            r_seg   <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iValid) begin
                        r_data  <= iData;
                        r_rec   <= iRecovery_info;
                        r_count <= w_count;
                        r_zero  <= (iData == '0);
                        r_seg   <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (!iFifo_full) begin
                        r_seg  <= r_seg + CNT_W'(1);
                        r_data <= r_data << SEG_W;
                        if (w_final)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
